// File: rtl/sampler_pkg.sv
// Shared types and xorshift32 constants for the constraint rejection sampler.
package sampler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    CHECK,
    DONE
  } state_t;

  localparam int          XS_A          = 13;
  localparam int          XS_B          = 17;
  localparam int          XS_C          = 5;
  localparam logic [31:0] ZERO_SEED_SUB = 32'h1;

  function automatic logic [31:0] xs32_next(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << XS_A);
    y = y ^ (y >> XS_B);
    y = y ^ (y << XS_C);
    return y;
  endfunction

endpackage

// File: rtl/sampler_xorshift32.sv
// xorshift32 state register: load (zero seed mapped to ZERO_SEED_SUB) beats step; one word per step.
module sampler_xorshift32
  import sampler_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        step,
  output logic [31:0] q
);

  // An all-zero state would lock xorshift at zero forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= ZERO_SEED_SUB;
    end else if (load) begin
      q <= (load_val == 32'h0) ? ZERO_SEED_SUB : load_val;
    end else if (step) begin
      q <= xs32_next(q);
    end
  end

endmodule

// File: rtl/constraint_rejection_sampler.sv
// Fills a VEC_W candidate from xorshift32 one chunk per cycle and retries until the checker accepts or MAX_TRIES runs out.
// Start-to-out_valid is tries*(NCH+1)+1 cycles; the result is held in DONE until out_ready.
module constraint_rejection_sampler
  import sampler_pkg::*;
#(
  parameter int VEC_W     = 232,
  parameter int CHUNK_W   = 32,
  parameter int MAX_TRIES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [31:0]                    seed,
  output logic                           busy,
  output logic [VEC_W-1:0]               cand,
  input  logic                           sat,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [VEC_W-1:0]               out_sample,
  output logic                           out_fail,
  output logic [$clog2(MAX_TRIES+1)-1:0] out_tries
);

  localparam int NCH = (VEC_W + CHUNK_W - 1) / CHUNK_W;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW  = $clog2(MAX_TRIES + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    chunk_q;
  logic [TW-1:0]    tries_q;
  logic [VEC_W-1:0] cand_q, cand_fill, out_sample_q;
  logic             out_valid_q, out_fail_q;
  logic             prng_load, prng_step;
  logic [31:0]      prng_q, prng_nxt;
  logic             last_chunk, budget_spent;

  sampler_xorshift32 u_prng (
    .clk      (clk),
    .rst      (rst),
    .load     (prng_load),
    .load_val (seed),
    .step     (prng_step),
    .q        (prng_q)
  );

  assign prng_nxt     = xs32_next(prng_q);
  assign last_chunk   = (chunk_q == CW'(NCH - 1));
  assign budget_spent = (tries_q == TW'(MAX_TRIES));

  // The top chunk may be partial; PRNG bits that land above VEC_W-1 are dropped.
  always_comb begin
    cand_fill = cand_q;
    for (int b = 0; b < VEC_W; b++) begin
      if (b / CHUNK_W == int'(chunk_q)) cand_fill[b] = prng_nxt[b % CHUNK_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    prng_load = 1'b0;
    prng_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          prng_load = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        prng_step = 1'b1;
        if (last_chunk) state_d = CHECK;
      end
      CHECK: begin
        state_d = (sat || budget_spent) ? DONE : FILL;
      end
      DONE: begin
        if (out_valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      chunk_q      <= '0;
      tries_q      <= '0;
      cand_q       <= '0;
      out_sample_q <= '0;
      out_fail_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            chunk_q <= '0;
            tries_q <= '0;
          end
        end
        FILL: begin
          cand_q <= cand_fill;
          if (last_chunk) begin
            chunk_q <= '0;
            if (!budget_spent) tries_q <= tries_q + TW'(1);
          end else begin
            chunk_q <= chunk_q + CW'(1);
          end
        end
        CHECK: begin
          // Acceptance takes precedence over an exhausted budget.
          if (sat || budget_spent) begin
            out_sample_q <= cand_q;
            out_fail_q   <= !sat;
            out_valid_q  <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q != IDLE);
  assign cand       = cand_q;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign out_fail   = out_fail_q;
  assign out_tries  = tries_q;

endmodule

// File: tb/tb_constraint_rejection_sampler.sv
// Randomized scoreboard bench for constraint_rejection_sampler with a sequence-level reference model.
module tb_constraint_rejection_sampler;

  localparam int VEC_W = 232;
  localparam int NCH   = 8;

  typedef struct {
    logic [VEC_W-1:0] sample;
    logic             fail;
    int               tries;
    int               lat;
    int               c0;
    logic             has_lo;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, out_ready, sat, busy, out_valid, out_fail;
  logic [31:0]      seed;
  logic [VEC_W-1:0] cand, out_sample;
  logic [10:0]      out_tries;
  logic             s_start, s_busy, s_valid, s_fail;
  logic [31:0]      s_seed;
  logic [VEC_W-1:0] s_cand, s_sample;
  logic [2:0]       s_tries;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   mode  = 0;
  int   rdy_mode = 0;
  exp_t exp_q[$];
  exp_t sq[$];

  always #5 clk = ~clk;

  function automatic bit pred(input int m, input logic [VEC_W-1:0] v);
    case (m)
      0:       return 1'b1;
      1:       return v[7:0] == 8'h00;
      2:       return 1'b0;
      default: return v[3:0] == 4'h0;
    endcase
  endfunction

  assign sat = pred(mode, cand);

  constraint_rejection_sampler #(.VEC_W(VEC_W), .CHUNK_W(32), .MAX_TRIES(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .busy(busy), .cand(cand), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .out_sample(out_sample),
    .out_fail(out_fail), .out_tries(out_tries)
  );

  constraint_rejection_sampler #(.VEC_W(VEC_W), .CHUNK_W(32), .MAX_TRIES(4)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .seed(s_seed), .busy(s_busy), .cand(s_cand), .sat(1'b0),
    .out_valid(s_valid), .out_ready(1'b1), .out_sample(s_sample),
    .out_fail(s_fail), .out_tries(s_tries)
  );

  function automatic logic [31:0] xs(input logic [31:0] x);
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  // One request: keep drawing NCH-word candidates until the predicate holds or the budget is gone.
  function automatic exp_t model(input logic [31:0] sd, input int m, input int maxt, input int c0);
    exp_t        e;
    logic [31:0]  x;
    logic [255:0] w;
    x = (sd == 32'h0) ? 32'h1 : sd;
    e.sample = '0;
    e.fail   = 1'b1;
    e.tries  = 0;
    for (int t = 1; t <= maxt; t++) begin
      w = '0;
      for (int k = 0; k < NCH; k++) begin
        x = xs(x);
        w = w | (256'(x) << (32 * k));
      end
      e.sample = w[VEC_W-1:0];
      e.tries  = t;
      e.fail   = !pred(m, e.sample);
      if (!e.fail) break;
    end
    e.lat    = e.tries * (NCH + 1) + 1;
    e.c0     = c0;
    e.has_lo = 1'b0;
    return e;
  endfunction

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
  end

  // Main-DUT monitor: latency on first valid, stability while stalled, contents on handshake.
  initial begin
    exp_t             e;
    logic             first_seen, hold, post, hf;
    logic [VEC_W-1:0] hs;
    logic [10:0]      ht;
    first_seen = 0; hold = 0; post = 0; hf = 0; hs = '0; ht = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        first_seen = 0; hold = 0; post = 0;
      end else begin
        if (post) check("idle_after_accept", 256'(busy), 256'(0));
        post = 0;
        if (hold) begin
          check("hold_valid", 256'(out_valid), 256'(1));
          check("hold_busy", 256'(busy), 256'(1));
          check("hold_sample", 256'(out_sample), 256'(hs));
          check("hold_fail", 256'(out_fail), 256'(hf));
          check("hold_tries", 256'(out_tries), 256'(ht));
        end
        hold = 0;
        if (out_valid && !first_seen) begin
          first_seen = 1;
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_out: out_valid=1 with nothing requested, want out_valid=0");
          end else begin
            check("latency", 256'(cyc - exp_q[0].c0), 256'(exp_q[0].lat));
          end
        end
        if (out_valid && out_ready) begin
          first_seen = 0;
          post = 1;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sample", 256'(out_sample), 256'(e.sample));
            check("fail", 256'(out_fail), 256'(e.fail));
            check("tries", 256'(out_tries), 256'(e.tries));
            if (e.has_lo) check("cand_lo_word", 256'(out_sample[31:0]), 256'(32'h00042021));
          end
        end else if (out_valid) begin
          hold = 1; hs = out_sample; hf = out_fail; ht = out_tries;
        end
      end
    end
  end

  // Small-budget DUT monitor (out_ready tied high, sat tied low).
  initial begin
    exp_t se;
    forever begin
      @(negedge clk);
      if (!rst && s_valid) begin
        if (sq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL small_unexpected_out: out_valid=1 with nothing requested, want 0");
        end else begin
          se = sq.pop_front();
          check("small_latency", 256'(cyc - se.c0), 256'(se.lat));
          check("small_fail", 256'(s_fail), 256'(se.fail));
          check("small_tries", 256'(s_tries), 256'(se.tries));
          check("small_sample", 256'(s_sample), 256'(se.sample));
        end
      end
    end
  end

  task automatic request(input logic [31:0] sd, input int m, input bit expect_out, input bit has_lo);
    exp_t e;
    mode  = m;
    seed  = sd;
    start = 1'b1;
    if (expect_out) begin
      e = model(sd, m, 1024, cyc);
      e.has_lo = has_lo;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || busy) && g < 20000) begin
      @(posedge clk); #1;
      g++;
    end
    check("done_in_budget", 256'(exp_q.size() != 0 || busy), 256'(0));
  endtask

  task automatic s_request(input logic [31:0] sd);
    int g;
    s_seed  = sd;
    s_start = 1'b1;
    sq.push_back(model(sd, 2, 4, cyc));
    @(posedge clk); #1;
    s_start = 1'b0;
    g = 0;
    while ((sq.size() != 0 || s_busy) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("small_done_in_budget", 256'(sq.size() != 0 || s_busy), 256'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_valid"}, 256'(out_valid), 256'(0));
    check({tag, "_cand"}, 256'(cand), 256'(0));
    check({tag, "_sample"}, 256'(out_sample), 256'(0));
    check({tag, "_fail"}, 256'(out_fail), 256'(0));
    check({tag, "_tries"}, 256'(out_tries), 256'(0));
  endtask

  initial begin
    int g;
    rst = 1'b1; start = 1'b0; seed = '0; s_start = 1'b0; s_seed = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    check("reset_small_valid", 256'(s_valid), 256'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    request(32'h1, 0, 1, 1);          wait_done();
    request(32'h0, 0, 1, 1);          wait_done();
    request(32'hDEADBEEF, 1, 1, 0);   wait_done();

    s_request(32'h1234_5678);
    s_request(32'h0);

    rdy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      request($urandom, 3, 1, 0);
      wait_done();
    end
    for (int i = 0; i < 2; i++) begin
      request($urandom, 1, 1, 0);
      wait_done();
    end

    // Result stalled for 20 cycles; a start issued meanwhile must be dropped.
    rdy_mode = 2;
    @(posedge clk); #1;
    request($urandom, 0, 1, 0);
    g = 0;
    while (!out_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    for (int i = 0; i < 20; i++) begin
      check("stall_valid", 256'(out_valid), 256'(1));
      check("stall_busy", 256'(busy), 256'(1));
      seed  = $urandom;
      start = (i == 5);
      @(posedge clk); #1;
    end
    start = 1'b0;
    rdy_mode = 0;
    wait_done();
    repeat (30) @(posedge clk);
    #1;

    // Reset in the middle of the third attempt's fill.
    request($urandom, 2, 0, 0);
    repeat (2 * (NCH + 1) + 3) @(posedge clk);
    #1;
    check("pre_reset_busy", 256'(busy), 256'(1));
    rst = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    request($urandom, 3, 1, 0);
    wait_done();
    request(32'h1, 0, 1, 1);
    wait_done();
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #950000;
    n_err++;
    $display("FAIL watchdog: simulation still running at 95000 cycles, want finished");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

endmodule
